// File: rtl/main_memory_ctrl_if.sv
// Cache-to-backing-store bus: refill read bursts, single-word writes, optional stat counters.
// master = cache side (drives requests), slave = memory side (drives responses).
interface main_memory_ctrl_if #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
);
  localparam int BEAT_W = $clog2(LINE_WORDS);

  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic [BEAT_W-1:0] mem_beat;
  logic              mem_wdone;
  logic [15:0]       stat_rd_cnt;
  logic [15:0]       stat_wr_cnt;

  modport master (
    output mem_re, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata, mem_beat, mem_wdone,
    input  stat_rd_cnt, stat_wr_cnt
  );

  modport slave (
    input  mem_re, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata, mem_beat, mem_wdone,
    output stat_rd_cnt, stat_wr_cnt
  );
endinterface

// File: rtl/main_memory_ctrl.sv
// Backing store behind the cache: line-aligned read bursts and single-word writes; MEM_STATS_EN adds counters.
// Latency: first beat / write-done LAT cycles after acceptance; busy LAT+LINE_WORDS (read) or LAT+1 (write).
// Backpressure: mem_ready low while busy, requests then ignored; beats are not flow-controlled.
module main_memory_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LINE_WORDS  = 4,
  parameter int LAT         = 3
) (
  input  logic             clk,
  input  logic             reset,
  main_memory_ctrl_if.slave bus
);
  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int CNT_W  = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RBURST, WDONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic               is_wr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               accept;
  logic               wr_commit;
  logic               burst_last;
  logic [IDX_W-1:0]   rd_idx;
  logic [DATA_W-1:0]  rd_arr [DEPTH_WORDS];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    accept     = 1'b0;
    wr_commit  = 1'b0;
    burst_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_re || bus.mem_we) begin
          accept  = 1'b1;
          state_d = WAIT;
          cnt_d   = CNT_W'(LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = is_wr_q ? WDONE : RBURST;
          beat_d  = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RBURST: begin
        beat_d = beat_q + BEAT_W'(1);
        if (beat_q == BEAT_W'(LINE_WORDS - 1)) begin
          burst_last = 1'b1;
          state_d    = IDLE;
          beat_d     = '0;
        end
      end
      WDONE: begin
        wr_commit = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write data wins when both request strobes are high at acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      is_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      if (accept) begin
        is_wr_q <= bus.mem_we;
        idx_q   <= bus.mem_addr[IDX_W-1:0];
        wdata_q <= bus.mem_wdata;
      end
    end
  end

  // Storage powers up holding its own index and is never cleared by reset.
  for (genvar g = 0; g < DEPTH_WORDS; g++) begin : g_word
    logic [DATA_W-1:0] word_q = DATA_W'(g);
    always_ff @(posedge clk) begin
      if (!reset && wr_commit && (idx_q == IDX_W'(g))) begin
        word_q <= wdata_q;
      end
    end
    assign rd_arr[g] = word_q;
  end

  if (ADDR_W > IDX_W) begin : g_alias
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.mem_addr[ADDR_W-1:IDX_W];
  end

  // Burst base is the line-aligned index, so beats never leave the line.
  assign rd_idx         = {idx_q[IDX_W-1:BEAT_W], beat_q};
  assign bus.mem_ready  = (state_q == IDLE);
  assign bus.mem_rvalid = (state_q == RBURST);
  assign bus.mem_wdone  = (state_q == WDONE);
  assign bus.mem_beat   = beat_q;
  assign bus.mem_rdata  = (state_q == RBURST) ? rd_arr[rd_idx] : '0;

`ifdef MEM_STATS_EN
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (burst_last) rd_cnt_q <= rd_cnt_q + 16'd1;
      if (wr_commit)  wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign bus.stat_rd_cnt = rd_cnt_q;
  assign bus.stat_wr_cnt = wr_cnt_q;
`else
  logic unused_stat_evt;
  assign unused_stat_evt = burst_last;
  assign bus.stat_rd_cnt = 16'd0;
  assign bus.stat_wr_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Scoreboard bench for main_memory_ctrl: directed cases, random traffic, mid-operation resets.
module tb_main_memory_ctrl;
  localparam int LAT   = 3;
  localparam int LW    = 4;
  localparam int DEPTH = 1024;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;
  bit done   = 1'b0;

  typedef struct {
    bit          is_wr;
    int          beat;
    logic [31:0] data;
    int          idx;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [DEPTH];
  logic [15:0] exp_rd = 16'd0;
  logic [15:0] exp_wr = 16'd0;

  main_memory_ctrl_if #(.ADDR_W(16), .DATA_W(32), .LINE_WORDS(LW)) bus ();

  main_memory_ctrl #(
    .ADDR_W(16), .DATA_W(32), .DEPTH_WORDS(DEPTH), .LINE_WORDS(LW), .LAT(LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] stat_exp(input logic [15:0] v);
`ifdef MEM_STATS_EN
    return v;
`else
    return 16'd0 & v;
`endif
  endfunction

  task automatic check_stats();
    chk("stat_rd_cnt", 32'(bus.stat_rd_cnt), 32'(stat_exp(exp_rd)));
    chk("stat_wr_cnt", 32'(bus.stat_wr_cnt), 32'(stat_exp(exp_wr)));
  endtask

  // Monitor: every output event must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    wait (mon_on);
    while (!done) begin
      @(negedge clk);
      if (bus.mem_rvalid || bus.mem_wdone) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {30'd0, bus.mem_rvalid, bus.mem_wdone}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("out_cycle", 32'(cyc), 32'(e.cyc));
          chk("wdone", 32'(bus.mem_wdone), 32'(e.is_wr));
          chk("rvalid", 32'(bus.mem_rvalid), 32'(!e.is_wr));
          if (e.is_wr) begin
            ref_mem[e.idx] = e.data;
            exp_wr++;
          end else begin
            chk("beat", 32'(bus.mem_beat), 32'(e.beat));
            chk("rdata", bus.mem_rdata, e.data);
            if (e.beat == LW - 1) exp_rd++;
          end
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("missed_output", 32'(cyc), 32'(exp_q[0].cyc));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.mem_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_req", 32'(bus.mem_ready), 32'd1);
  endtask

  // Issues one request, queues its expected response, then hammers the
  // inputs with junk while busy and measures how long mem_ready stays low.
  task automatic do_req(input bit re, input bit we, input logic [15:0] addr, input logic [31:0] data);
    int   n;
    int   t0;
    int   occ;
    int   base;
    exp_t e;
    wait_ready();
    bus.mem_re    = re;
    bus.mem_we    = we;
    bus.mem_addr  = addr;
    bus.mem_wdata = data;
    @(posedge clk);
    #1;
    t0 = cyc;
    if (we) begin
      e.is_wr = 1'b1;
      e.beat  = 0;
      e.data  = data;
      e.idx   = int'(addr[9:0]);
      e.cyc   = t0 + LAT;
      exp_q.push_back(e);
      occ = LAT + 1;
    end else begin
      base = (int'(addr[9:0]) / LW) * LW;
      for (int k = 0; k < LW; k++) begin
        e.is_wr = 1'b0;
        e.beat  = k;
        e.data  = ref_mem[base + k];
        e.idx   = base + k;
        e.cyc   = t0 + LAT + k;
        exp_q.push_back(e);
      end
      occ = LAT + LW;
    end
    n = 0;
    do begin
      bus.mem_re    = 1'b1;
      bus.mem_we    = ($urandom_range(0, 3) == 0);
      bus.mem_addr  = 16'($urandom);
      bus.mem_wdata = $urandom;
      @(negedge clk);
      n++;
    end while (!bus.mem_ready && n < 200);
    bus.mem_re = 1'b0;
    bus.mem_we = 1'b0;
    chk("occupancy", 32'(cyc - t0), 32'(occ));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i);
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    mon_on = 1'b1;

    chk("rst_ready",  32'(bus.mem_ready),  32'd1);
    chk("rst_rvalid", 32'(bus.mem_rvalid), 32'd0);
    chk("rst_wdone",  32'(bus.mem_wdone),  32'd0);
    chk("rst_rdata",  bus.mem_rdata,       32'd0);
    chk("rst_beat",   32'(bus.mem_beat),   32'd0);
    chk("rst_stat_rd", 32'(bus.stat_rd_cnt), 32'd0);
    chk("rst_stat_wr", 32'(bus.stat_wr_cnt), 32'd0);

    do_req(1'b1, 1'b0, 16'd9, 32'd0);
    check_stats();
    do_req(1'b0, 1'b1, 16'd2, 32'hAAAA_AAAA);
    do_req(1'b1, 1'b0, 16'd0, 32'd0);
    check_stats();
    do_req(1'b1, 1'b1, 16'd5, 32'h1234_5678);
    do_req(1'b1, 1'b0, 16'd4, 32'd0);
    check_stats();

    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 4));
      do_req((r != 3), (r >= 3), 16'($urandom) & 16'hFC1F, $urandom);
    end
    check_stats();

    // Reset during beat 1 of a burst from address 0.
    wait_ready();
    bus.mem_re   = 1'b1;
    bus.mem_addr = 16'd0;
    @(posedge clk);
    #1;
    for (int k = 0; k < LW; k++) begin
      exp_t e;
      e.is_wr = 1'b0;
      e.beat  = k;
      e.data  = ref_mem[k];
      e.idx   = k;
      e.cyc   = cyc + LAT + k;
      exp_q.push_back(e);
    end
    bus.mem_re = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    exp_rd = 16'd0;
    exp_wr = 16'd0;
    reset  = 1'b0;
    @(negedge clk);
    chk("midburst_rvalid", 32'(bus.mem_rvalid), 32'd0);
    chk("midburst_ready",  32'(bus.mem_ready),  32'd1);
    chk("midburst_stat_rd", 32'(bus.stat_rd_cnt), 32'd0);

    // Reset while a write is still waiting: the write must vanish.
    bus.mem_we    = 1'b1;
    bus.mem_addr  = 16'h0302;
    bus.mem_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.mem_we = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(bus.mem_ready), 32'd1);
    chk("abort_wdone", 32'(bus.mem_wdone), 32'd0);
    do_req(1'b1, 1'b0, 16'h0302, 32'd0);
    check_stats();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
